bk_axi_lite_ctrl: RTL and testbench
===================================

Name: bk_axi_lite_ctrl

Overview:
AXI4-Lite slave that fronts the 16-word block configuration register stage. It holds 16 host-writable config words and exposes 16 status words from the stage for readback. It also implements an AP_CTRL register that emits a single-cycle ap_start pulse and captures ap_done into a sticky, clear-on-read flag. It sits directly upstream of the register-config stage: its cfg/start outputs feed that stage, and that stage's status/done outputs feed back into it.

Parameters:
ADDR_W, 8, AXI address width; only bits [7:2] are decoded, bits [1:0] are ignored
NUM_REGS, 16, number of config/status words (fixed map below assumes 16)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out/in  1  R handshake
ap_start_pedge  out  1  one-cycle start pulse to the config stage
ap_done_i  in  1  one-cycle done pulse from the config stage
cfg_reg0_o..cfg_reg15_o  out  32 each  config words, to the stage's register inputs
stat_reg0_i..stat_reg15_i  in  32 each  status words, from the stage's register outputs

Behaviour:
- Reset values: all outputs 0, including bvalid, rvalid, rdata, bresp, rresp, ap_start_pedge and all cfg regs. Internal busy=0, done=0. The ready outputs are 0 while rst is high.
- Address map (byte address):
  - 0x00 AP_CTRL: bit0 start (W1, reads busy), bit1 done (RO, clear-on-read), bit2 idle (RO, equals !busy). Other bits read 0.
  - 0x10+4n: cfg_reg n, R/W, n=0..15.
  - 0x50+4n: stat_reg n, RO; writes are ignored and return OKAY.
  - Any other address: SLVERR (2'b10) on both read and write. Read data is 0.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W are accepted independently, in either order or in the same cycle.
  - The register update occurs in the cycle after both address and data are held. bvalid rises in that same cycle.
  - bvalid is held until bready; aw_held and w_held clear on the B handshake. There is at most one outstanding write.
- WSTRB: byte k of the target cfg register updates only if wstrb[k]=1. For AP_CTRL, only wstrb[0] is significant.
- Start:
  - A write to AP_CTRL with bit0=1 and wstrb[0]=1 while busy=0 asserts ap_start_pedge for exactly one cycle, concurrent with bvalid rising, and sets busy.
  - The same write while busy=1 is ignored (no pulse) but still returns OKAY.
- Done: ap_done_i=1 clears busy and sets done. If ap_done_i and a start write occur in the same cycle, the done is processed first, so the start is accepted and busy ends at 1.
- Read channel:
  - arready = !rvalid. On the AR handshake, rdata/rresp are registered next cycle with rvalid=1, held stable until rready.
  - Read latency is 1 cycle minimum. Back-to-back reads are possible only after the R handshake.
- Clear-on-read: done clears on the AR handshake that targets 0x00. The returned value reflects done before clearing. If ap_done_i=1 in that same cycle, done stays 1 (set wins).
- Read/write collision: a read and a write to the same cfg address in the same cycle return the pre-write value.
- Mid-operation reset: everything returns to reset values immediately. Any pending B/R response is dropped and the master must re-issue.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x14 (strb 0xF) and read 0x14 -> bresp=0, cfg_reg1_o=0xDEADBEEF, rdata=0xDEADBEEF, rresp=0.
2. Write 0x000000AA to 0x14 with strb 0x1 over the value 0xDEADBEEF -> cfg_reg1_o=0xDEADBEAA. Then present W two cycles before AW -> single bvalid, value correct.
3. Write 1 to 0x00 -> ap_start_pedge high for exactly 1 cycle and a read of 0x00 returns 0x1. A second start write while busy -> no pulse, OKAY.
4. Pulse ap_done_i -> a read of 0x00 returns 0x6 and the next read returns 0x4. ap_done_i coincident with the read AR handshake -> the next read still returns 0x6.
5. Drive stat_reg15_i=0x12345678 and read 0x8C -> 0x12345678. Read 0x90 and write 0xFC -> rresp=2'b10 with rdata=0, bresp=2'b10, no cfg change.
6. Hold rready=0 for 5 cycles -> rvalid and rdata stay stable and arready stays 0. Assert rst mid-write -> bvalid=0, all cfg regs 0.

Source files
------------

// File: rtl/bk_axi_lite_ctrl.sv
// AXI4-Lite slave for the 16-word block config stage: config words, status readback,
// and an AP_CTRL register with a start pulse and a sticky clear-on-read done flag.
module bk_axi_lite_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              ap_start_pedge,
  input  logic              ap_done_i,
  output logic [31:0]       cfg_reg0_o,
  output logic [31:0]       cfg_reg1_o,
  output logic [31:0]       cfg_reg2_o,
  output logic [31:0]       cfg_reg3_o,
  output logic [31:0]       cfg_reg4_o,
  output logic [31:0]       cfg_reg5_o,
  output logic [31:0]       cfg_reg6_o,
  output logic [31:0]       cfg_reg7_o,
  output logic [31:0]       cfg_reg8_o,
  output logic [31:0]       cfg_reg9_o,
  output logic [31:0]       cfg_reg10_o,
  output logic [31:0]       cfg_reg11_o,
  output logic [31:0]       cfg_reg12_o,
  output logic [31:0]       cfg_reg13_o,
  output logic [31:0]       cfg_reg14_o,
  output logic [31:0]       cfg_reg15_o,
  input  logic [31:0]       stat_reg0_i,
  input  logic [31:0]       stat_reg1_i,
  input  logic [31:0]       stat_reg2_i,
  input  logic [31:0]       stat_reg3_i,
  input  logic [31:0]       stat_reg4_i,
  input  logic [31:0]       stat_reg5_i,
  input  logic [31:0]       stat_reg6_i,
  input  logic [31:0]       stat_reg7_i,
  input  logic [31:0]       stat_reg8_i,
  input  logic [31:0]       stat_reg9_i,
  input  logic [31:0]       stat_reg10_i,
  input  logic [31:0]       stat_reg11_i,
  input  logic [31:0]       stat_reg12_i,
  input  logic [31:0]       stat_reg13_i,
  input  logic [31:0]       stat_reg14_i,
  input  logic [31:0]       stat_reg15_i
);

  // word index space: 0 = AP_CTRL, 4..19 = cfg, 20..35 = stat
  localparam int CFG_BASE  = 4;
  localparam int STAT_BASE = CFG_BASE + NUM_REGS;
  localparam int IDX_W     = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] cfg_q  [NUM_REGS];
  logic [31:0] stat_w [NUM_REGS];

  logic             aw_held;
  logic             w_held;
  logic [5:0]       aw_idx;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             busy;
  logic             done;

  logic             do_write;
  logic             start_ok;
  logic             ar_hs;
  logic [5:0]       ar_idx;
  logic             wr_ctrl;
  logic             wr_cfg;
  logic             wr_stat;
  logic [IDX_W-1:0] wr_sel;
  logic             rd_cfg;
  logic             rd_stat;
  logic [31:0]      rd_data;
  logic             rd_err;
  logic             unused_addr;

  assign unused_addr = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign stat_w[0]  = stat_reg0_i;
  assign stat_w[1]  = stat_reg1_i;
  assign stat_w[2]  = stat_reg2_i;
  assign stat_w[3]  = stat_reg3_i;
  assign stat_w[4]  = stat_reg4_i;
  assign stat_w[5]  = stat_reg5_i;
  assign stat_w[6]  = stat_reg6_i;
  assign stat_w[7]  = stat_reg7_i;
  assign stat_w[8]  = stat_reg8_i;
  assign stat_w[9]  = stat_reg9_i;
  assign stat_w[10] = stat_reg10_i;
  assign stat_w[11] = stat_reg11_i;
  assign stat_w[12] = stat_reg12_i;
  assign stat_w[13] = stat_reg13_i;
  assign stat_w[14] = stat_reg14_i;
  assign stat_w[15] = stat_reg15_i;

  assign cfg_reg0_o  = cfg_q[0];
  assign cfg_reg1_o  = cfg_q[1];
  assign cfg_reg2_o  = cfg_q[2];
  assign cfg_reg3_o  = cfg_q[3];
  assign cfg_reg4_o  = cfg_q[4];
  assign cfg_reg5_o  = cfg_q[5];
  assign cfg_reg6_o  = cfg_q[6];
  assign cfg_reg7_o  = cfg_q[7];
  assign cfg_reg8_o  = cfg_q[8];
  assign cfg_reg9_o  = cfg_q[9];
  assign cfg_reg10_o = cfg_q[10];
  assign cfg_reg11_o = cfg_q[11];
  assign cfg_reg12_o = cfg_q[12];
  assign cfg_reg13_o = cfg_q[13];
  assign cfg_reg14_o = cfg_q[14];
  assign cfg_reg15_o = cfg_q[15];

  assign s_axi_awready = !rst && !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !rst && !w_held && !s_axi_bvalid;
  assign s_axi_arready = !rst && !s_axi_rvalid;

  assign ar_idx   = s_axi_araddr[7:2];
  assign ar_hs    = s_axi_arvalid && s_axi_arready;
  assign do_write = aw_held && w_held && !s_axi_bvalid;
  // a done arriving in the same cycle frees the engine, so the start is still taken
  assign start_ok = do_write && wr_ctrl && wdata_q[0] && wstrb_q[0] && (!busy || ap_done_i);

  always_comb begin
    wr_ctrl = (aw_idx == 6'd0);
    wr_cfg  = (int'(aw_idx) >= CFG_BASE) && (int'(aw_idx) < STAT_BASE);
    wr_stat = (int'(aw_idx) >= STAT_BASE) && (int'(aw_idx) < STAT_BASE + NUM_REGS);
    wr_sel  = IDX_W'(aw_idx - 6'(CFG_BASE));
    rd_cfg  = (int'(ar_idx) >= CFG_BASE) && (int'(ar_idx) < STAT_BASE);
    rd_stat = (int'(ar_idx) >= STAT_BASE) && (int'(ar_idx) < STAT_BASE + NUM_REGS);
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (ar_idx == 6'd0) begin
      rd_data = {29'd0, ~busy, done, busy};
    end else if (rd_cfg) begin
      rd_data = cfg_q[IDX_W'(ar_idx - 6'(CFG_BASE))];
    end else if (rd_stat) begin
      rd_data = stat_w[IDX_W'(ar_idx - 6'(STAT_BASE))];
    end else begin
      rd_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_idx         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ap_start_pedge <= 1'b0;
      s_axi_bvalid   <= 1'b0;
      s_axi_bresp    <= RESP_OKAY;
      s_axi_rvalid   <= 1'b0;
      s_axi_rdata    <= '0;
      s_axi_rresp    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= '0;
    end else begin
      ap_start_pedge <= start_ok;

      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[7:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end

      if (do_write) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (wr_ctrl || wr_cfg || wr_stat) ? RESP_OKAY : RESP_SLVERR;
        if (wr_cfg) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel == IDX_W'(i)) begin
              for (int k = 0; k < 4; k++) begin
                if (wstrb_q[k]) cfg_q[i][8*k +: 8] <= wdata_q[8*k +: 8];
              end
            end
          end
        end
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end

      if (start_ok) busy <= 1'b1;
      else if (ap_done_i) busy <= 1'b0;

      // a done pulse landing on the clearing read must not be lost
      if (ap_done_i) done <= 1'b1;
      else if (ar_hs && ar_idx == 6'd0) done <= 1'b0;

      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bk_axi_lite_ctrl.sv
// Bench for bk_axi_lite_ctrl: directed sequences plus random AXI traffic, checked every
// cycle against a register-map model, with literal expectations pinning the model.
module tb_bk_axi_lite_ctrl;

  logic        clk, rst;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready, ap_done_i;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, ap_start;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] cfg_o  [16];
  logic [31:0] stat_i [16];

  int checks = 0;
  int failures = 0;

  bk_axi_lite_ctrl #(.ADDR_W(8), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ap_start_pedge(ap_start), .ap_done_i(ap_done_i),
    .cfg_reg0_o(cfg_o[0]), .cfg_reg1_o(cfg_o[1]), .cfg_reg2_o(cfg_o[2]), .cfg_reg3_o(cfg_o[3]),
    .cfg_reg4_o(cfg_o[4]), .cfg_reg5_o(cfg_o[5]), .cfg_reg6_o(cfg_o[6]), .cfg_reg7_o(cfg_o[7]),
    .cfg_reg8_o(cfg_o[8]), .cfg_reg9_o(cfg_o[9]), .cfg_reg10_o(cfg_o[10]), .cfg_reg11_o(cfg_o[11]),
    .cfg_reg12_o(cfg_o[12]), .cfg_reg13_o(cfg_o[13]), .cfg_reg14_o(cfg_o[14]), .cfg_reg15_o(cfg_o[15]),
    .stat_reg0_i(stat_i[0]), .stat_reg1_i(stat_i[1]), .stat_reg2_i(stat_i[2]), .stat_reg3_i(stat_i[3]),
    .stat_reg4_i(stat_i[4]), .stat_reg5_i(stat_i[5]), .stat_reg6_i(stat_i[6]), .stat_reg7_i(stat_i[7]),
    .stat_reg8_i(stat_i[8]), .stat_reg9_i(stat_i[9]), .stat_reg10_i(stat_i[10]), .stat_reg11_i(stat_i[11]),
    .stat_reg12_i(stat_i[12]), .stat_reg13_i(stat_i[13]), .stat_reg14_i(stat_i[14]), .stat_reg15_i(stat_i[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] cfg_m [16];
  logic        busy_m, done_m;
  logic        m_aw, m_w, m_bv, m_rv, m_start;
  logic [5:0]  m_awidx;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        busy_n, done_n, hs_aw, hs_w, hs_ar, prev_bv;
  logic [31:0] rd_v, mask;
  logic        rd_e;
  int          widx;
  int          pulse_cnt = 0;
  int          bv_rise = 0;

  function automatic void mread(input int idx, output logic [31:0] d, output logic e);
    d = 32'd0;
    e = 1'b0;
    if (idx == 0) d = {29'd0, ~busy_m, done_m, busy_m};
    else if (idx >= 4 && idx < 20) d = cfg_m[idx-4];
    else if (idx >= 20 && idx < 36) d = stat_i[idx-20];
    else e = 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 16; i++) cfg_m[i] = 32'd0;
        {busy_m, done_m, m_aw, m_w, m_bv, m_rv, m_start} = '0;
        m_awidx = '0; m_wdata = '0; m_wstrb = '0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'd0;
      end else begin
        hs_aw = awvalid && !m_aw && !m_bv;
        hs_w  = wvalid && !m_w && !m_bv;
        hs_ar = arvalid && !m_rv;
        busy_n = busy_m;
        done_n = done_m;
        m_start = 1'b0;
        if (ap_done_i) begin busy_n = 1'b0; done_n = 1'b1; end
        if (hs_ar) begin
          mread(int'(araddr) / 4, rd_v, rd_e);
          m_rdata = rd_v;
          m_rresp = rd_e ? 2'b10 : 2'b00;
          m_rv = 1'b1;
          if (araddr[7:2] == 6'd0 && !ap_done_i) done_n = 1'b0;
        end else if (m_rv && rready) begin
          m_rv = 1'b0;
        end
        if (m_aw && m_w && !m_bv) begin
          widx = int'(m_awidx);
          m_bv = 1'b1;
          m_bresp = (widx == 0 || (widx >= 4 && widx < 36)) ? 2'b00 : 2'b10;
          if (widx >= 4 && widx < 20) begin
            mask = {{8{m_wstrb[3]}}, {8{m_wstrb[2]}}, {8{m_wstrb[1]}}, {8{m_wstrb[0]}}};
            cfg_m[widx-4] = (cfg_m[widx-4] & ~mask) | (m_wdata & mask);
          end
          if (widx == 0 && m_wdata[0] && m_wstrb[0] && !busy_n) begin
            m_start = 1'b1;
            busy_n = 1'b1;
          end
        end else if (m_bv && bready) begin
          m_bv = 1'b0; m_aw = 1'b0; m_w = 1'b0;
        end
        if (hs_aw) begin m_aw = 1'b1; m_awidx = awaddr[7:2]; end
        if (hs_w) begin m_w = 1'b1; m_wdata = wdata; m_wstrb = wstrb; end
        busy_m = busy_n;
        done_m = done_n;
      end
      #1;
      chk("awready", awready, !rst && !m_aw && !m_bv);
      chk("wready", wready, !rst && !m_w && !m_bv);
      chk("arready", arready, !rst && !m_rv);
      chk("bvalid", bvalid, m_bv);
      chk("bresp", bresp, m_bresp);
      chk("rvalid", rvalid, m_rv);
      chk("rdata", rdata, m_rdata);
      chk("rresp", rresp, m_rresp);
      chk("ap_start_pedge", ap_start, m_start);
      for (int i = 0; i < 16; i++) chk($sformatf("cfg%0d", i), cfg_o[i], cfg_m[i]);
      if (ap_start) pulse_cnt++;
      if (bvalid && !prev_bv) bv_rise++;
      prev_bv = bvalid;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_done = 1'b0;

  task automatic next_cycle();
    @(negedge clk);
    ap_done_i = rand_done && ($urandom_range(0, 11) == 0);
    if (rand_done && $urandom_range(0, 15) == 0) stat_i[$urandom_range(0, 15)] = $urandom;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_hold,
                           output logic [1:0] r);
    int n;
    bit aw_ok, w_ok;
    aw_ok = 0; w_ok = 0; n = 0;
    while (!(aw_ok && w_ok)) begin
      next_cycle();
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !aw_ok && (n >= aw_dly);
      wvalid  = !w_ok && (n >= w_dly);
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      n++;
      if (n > 60) begin tmo("aw_w_accept"); break; end
    end
    next_cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin next_cycle(); n++; end
    if (!bvalid) tmo("bvalid_wait");
    repeat (b_hold) next_cycle();
    bready = 1'b1;
    r = bresp;
    next_cycle();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, input int rr_hold, input bit done_with_ar,
                          output logic [31:0] d, output logic [1:0] r);
    int n;
    bit hs;
    n = 0; hs = 0;
    while (!hs) begin
      next_cycle();
      arvalid = 1'b1; araddr = a;
      if (done_with_ar && arready) ap_done_i = 1'b1;
      hs = arready;
      n++;
      if (n > 50) begin tmo("ar_accept"); break; end
    end
    next_cycle();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin next_cycle(); n++; end
    if (!rvalid) tmo("rvalid_wait");
    repeat (rr_hold) next_cycle();
    rready = 1'b1;
    d = rdata; r = rresp;
    next_cycle();
    rready = 1'b0;
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) a = 8'h00;
    else if (sel <= 3) a = 8'h10 + 8'($urandom_range(0, 15) * 4);
    else if (sel <= 5) a = 8'h50 + 8'($urandom_range(0, 15) * 4);
    else if (sel == 6) a = 8'($urandom_range(1, 3) * 4);
    else a = 8'h90 + 8'($urandom_range(0, 27) * 4);
    return a | 8'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int p0, b0;
    rst = 1'b1;
    {awvalid, wvalid, bready, arvalid, rready, ap_done_i} = '0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 16; i++) stat_i[i] = 32'h1000_0000 + i;
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_cfg1", cfg_o[1], 0);
    rst = 1'b0;

    // basic write/read
    axi_write(8'h14, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
    chk("t1_bresp", r, 2'b00);
    chk("t1_cfg1", cfg_o[1], 32'hDEADBEEF);
    axi_read(8'h14, 0, 0, d, r);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", r, 2'b00);

    // byte strobe, W ahead of AW
    axi_write(8'h14, 32'h000000AA, 4'h1, 0, 0, 1, r);
    chk("t2_cfg1_strb", cfg_o[1], 32'hDEADBEAA);
    b0 = bv_rise;
    axi_write(8'h18, 32'h0BADF00D, 4'hF, 2, 0, 0, r);
    chk("t2_single_bvalid", bv_rise - b0, 1);
    chk("t2_cfg2", cfg_o[2], 32'h0BADF00D);

    // start pulse and busy
    p0 = pulse_cnt;
    axi_write(8'h00, 32'h1, 4'h1, 0, 0, 0, r);
    chk("t3_pulse_count", pulse_cnt - p0, 1);
    axi_read(8'h00, 0, 0, d, r);
    chk("t3_ctrl_busy", d, 32'h1);
    p0 = pulse_cnt;
    axi_write(8'h00, 32'h1, 4'hF, 0, 0, 0, r);
    chk("t3_busy_no_pulse", pulse_cnt - p0, 0);
    chk("t3_busy_bresp", r, 2'b00);

    // done sticky / clear-on-read / set wins
    next_cycle(); ap_done_i = 1'b1;
    next_cycle();
    axi_read(8'h00, 0, 0, d, r);
    chk("t4_done_read", d, 32'h6);
    axi_read(8'h00, 0, 0, d, r);
    chk("t4_cleared", d, 32'h4);
    next_cycle(); ap_done_i = 1'b1;
    next_cycle();
    axi_read(8'h00, 0, 1, d, r);
    chk("t4_coinc_read", d, 32'h6);
    axi_read(8'h00, 0, 0, d, r);
    chk("t4_set_wins", d, 32'h6);
    axi_read(8'h00, 0, 0, d, r);
    chk("t4_final_clear", d, 32'h4);

    // status readback and decode errors
    stat_i[15] = 32'h12345678;
    axi_read(8'h8C, 0, 0, d, r);
    chk("t5_stat15", d, 32'h12345678);
    axi_read(8'h90, 0, 0, d, r);
    chk("t5_bad_rresp", r, 2'b10);
    chk("t5_bad_rdata", d, 32'h0);
    axi_write(8'hFC, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
    chk("t5_bad_bresp", r, 2'b10);
    chk("t5_cfg15_kept", cfg_o[15], 32'h0);
    axi_write(8'h54, 32'h77777777, 4'hF, 0, 0, 0, r);
    chk("t5_stat_wr_okay", r, 2'b00);

    // rready stall
    axi_read(8'h14, 5, 0, d, r);
    chk("t6_stall_rdata", d, 32'hDEADBEAA);

    // same-cycle read and write of one cfg word
    axi_write(8'h1C, 32'h0000CAFE, 4'hF, 0, 0, 0, r);
    next_cycle();
    awaddr = 8'h1C; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    next_cycle();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 8'h1C; rready = 1'b1;
    next_cycle();
    arvalid = 1'b0;
    chk("coll_rvalid", rvalid, 1);
    chk("coll_rdata_old", rdata, 32'h0000CAFE);
    next_cycle();
    rready = 1'b0; bready = 1'b0;
    chk("coll_cfg3_new", cfg_o[3], 32'h11112222);

    // random traffic
    rand_done = 1'b1;
    for (int i = 0; i < 16; i++) stat_i[i] = $urandom;
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 2), r);
      else
        axi_read(rand_addr(), $urandom_range(0, 3), 0, d, r);
    end
    rand_done = 1'b0;
    next_cycle();

    // reset in the middle of a write
    axi_write(8'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0, r);
    next_cycle();
    awaddr = 8'h20; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    next_cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    next_cycle();
    chk("t6_pre_rst_bvalid", bvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_bvalid", bvalid, 0);
    chk("t6_rst_awready", awready, 0);
    chk("t6_rst_start", ap_start, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("t6_rst_cfg%0d", i), cfg_o[i], 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    axi_write(8'h10, 32'h00C0FFEE, 4'hF, 0, 0, 0, r);
    axi_read(8'h10, 0, 0, d, r);
    chk("post_rst_rdata", d, 32'h00C0FFEE);
    axi_read(8'h00, 0, 0, d, r);
    chk("post_rst_ctrl", d, 32'h4);

    repeat (3) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
